// File: rtl/nfifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nfifo_pkg
// Purpose  : Shared definitions for the nFIFO write-port arbiter.
//            Default data width, state encoding and a ceil(log2) helper
//            used to size the source tag.
// Revision : 1.0  initial release
// ============================================================================
package nfifo_pkg;

    localparam int C_DW_DEFAULT = 12;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Smallest r with 2**r >= n (returns 0 for n <= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : nfifo_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin search. Returns the first asserted
//            req_valid bit starting at last_grant+1 and wrapping modulo NREQ.
// Ports    : req_valid  [NREQ-1:0] candidate requests
//            last_grant [SW-1:0]   most recently granted index
//            found                 any candidate asserted
//            idx        [SW-1:0]   selected index (0 when nothing found)
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int SW   = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [SW-1:0]   last_grant,
    output logic            found,
    output logic [SW-1:0]   idx
);

    // Position k steps after the last grant, wrapped modulo NREQ so that
    // unused codes of a non-power-of-2 NREQ are never produced.
    function automatic logic [SW-1:0] pos_of(input logic [SW-1:0] lg, input int k);
        return SW'((int'(lg) + k) % NREQ);
    endfunction

    // Walk from the farthest candidate to the nearest so the nearest match
    // (the round-robin winner) is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[pos_of(last_grant, k)]) begin
                found = 1'b1;
                idx   = pos_of(last_grant, k);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/nfifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nfifo_rr_arbiter
// Purpose  : Round-robin arbiter sharing the nFIFO write port among NREQ
//            valid/ready producers. One owner at a time for up to BURST_LEN
//            beats; accepted beats are forwarded one cycle later with a
//            source tag. All producers stall while fifo_full is high.
// Ports    : clk, reset (sync, active-high)
//            req_valid/req_data/req_ready  producer side (ready is comb.)
//            fifo_full                     nFIFO backpressure
//            fifo_wr_en/data/src           registered nFIFO write port
//            busy                          arbiter is inside a burst
// Revision : 1.0  initial release
// ============================================================================
module nfifo_rr_arbiter
    import nfifo_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = C_DW_DEFAULT,
    parameter int BURST_LEN = 4,
    parameter int SW        = clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic [DW-1:0]      fifo_wr_data,
    output logic [SW-1:0]      fifo_wr_src,
    output logic               busy
);

    localparam logic [3:0] C_BURST = 4'(BURST_LEN);

    logic [0:0]    r_state;
    logic [SW-1:0] r_owner;
    logic [SW-1:0] r_last_grant;
    logic [3:0]    r_cnt;
    logic          r_wr_en;
    logic [DW-1:0] r_wr_data;
    logic [SW-1:0] r_wr_src;

    logic          w_pick_found;
    logic [SW-1:0] w_pick_idx;
    logic          w_owner_valid;
    logic [SW-1:0] w_sel;
    logic          w_accept;
    logic [NREQ-1:0] w_ready;
    logic [DW-1:0] w_sel_data;

    rr_pick #(
        .NREQ (NREQ),
        .SW   (SW)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (r_last_grant),
        .found      (w_pick_found),
        .idx        (w_pick_idx)
    );

    always_comb begin
        w_owner_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == SW'(i)) begin
                w_owner_valid = req_valid[i];
            end
        end

        w_sel = (r_state == ST_IDLE) ? w_pick_idx : r_owner;

        // Only one requester can ever be ready, so acceptance is decided
        // once here and then steered to the selected index.
        w_accept = 1'b0;
        if (!reset && !fifo_full) begin
            if (r_state == ST_IDLE) begin
                w_accept = w_pick_found;
            end else begin
                w_accept = w_owner_valid && (r_cnt < C_BURST);
            end
        end

        w_ready    = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == SW'(i)) begin
                w_ready[i] = w_accept;
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_grant <= SW'(NREQ - 1);
            r_cnt        <= 4'd0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_wr_src     <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_data <= w_sel_data;
                r_wr_src  <= w_sel;
            end

            if (r_state == ST_IDLE) begin
                if (w_accept) begin
                    r_owner      <= w_pick_idx;
                    r_last_grant <= w_pick_idx;
                    r_cnt        <= 4'd1;
                    if (BURST_LEN > 1) begin
                        r_state <= ST_BURST;
                    end
                end
            end else if (!fifo_full) begin
                // Release costs one bubble cycle; a stall (fifo_full) keeps
                // the owner and count untouched.
                if (!w_owner_valid || (r_cnt >= C_BURST)) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    assign req_ready    = w_ready;
    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign fifo_wr_src  = r_wr_src;
    assign busy         = (r_state != ST_IDLE);

endmodule : nfifo_rr_arbiter
`default_nettype wire
